sint32_add_seq: RTL and testbench

Sequencer and arbiter that computes 32-bit signed add/subtract by time-multiplexing one external combinational 16-bit Kogge-Stone adder (built from black cells) over two cycles, low half then high half. Two requesters share the adder under round-robin arbitration. Each requester uses a valid/ready handshake, and results return on one valid/ready response channel tagged with the requester ID. The block sits between the adder clients and the `Sint16` KG adder instance.

---
 rtl/sint32_add_seq.sv | 127 ++++++++++++
 tb/tb_sint32_add_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sint32_add_seq.sv
// Two-requester sequencer that computes 32-bit signed add/subtract on a shared
// 16-bit combinational adder, low half first, then high half.
module sint32_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_sum,
    output logic        resp_ovf,
    output logic        resp_id,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state, state_nxt;
    logic        last;
    logic [31:0] a_q, bx_q;
    logic        sub_q, id_q;
    logic [15:0] sum_lo;
    logic        c16;
    logic        grant0, grant1, accept;

    logic [31:0] sel_a, sel_b;
    logic        sel_sub;

    assign accept  = req0_ready | req1_ready;
    assign sel_a   = grant1 ? req1_a   : req0_a;
    assign sel_b   = grant1 ? req1_b   : req0_b;
    assign sel_sub = grant1 ? req1_sub : req0_sub;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_nxt  = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                grant0     = req0_valid & (~req1_valid | last);
                grant1     = req1_valid & ~grant0;
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
                if (grant0 | grant1) state_nxt = LO;
            end
            LO: begin
                add_a     = a_q[15:0];
                add_b     = bx_q[15:0];
                add_cin   = sub_q;
                state_nxt = HI;
            end
            HI: begin
                add_a     = a_q[31:16];
                add_b     = bx_q[31:16];
                add_cin   = c16;
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 1'b1;
            a_q      <= '0;
            bx_q     <= '0;
            sub_q    <= 1'b0;
            id_q     <= 1'b0;
            sum_lo   <= '0;
            c16      <= 1'b0;
            resp_sum <= '0;
            resp_ovf <= 1'b0;
            resp_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // Subtraction is a + ~b + 1; the +1 enters as the low-half carry-in.
                    a_q   <= sel_a;
                    bx_q  <= sel_sub ? ~sel_b : sel_b;
                    sub_q <= sel_sub;
                    id_q  <= grant1;
                    last  <= grant1;
                end
                LO: begin
                    sum_lo <= add_sum;
                    c16    <= add_cout;
                end
                HI: begin
                    // The high-half carry-out is dropped; the result wraps modulo 2^32.
                    resp_sum <= {add_sum, sum_lo};
                    resp_ovf <= (a_q[31] == bx_q[31]) & (add_sum[15] != a_q[31]);
                    resp_id  <= id_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sint32_add_seq.sv
// Directed bench for sint32_add_seq with a behavioural 16-bit adder attached.
module tb_sint32_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_ovf, resp_id;
    logic [31:0] resp_sum;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External combinational adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    sint32_add_seq dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_ovf(resp_ovf), .resp_id(resp_id),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; DUT is observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // One operation on requester 0, starting in IDLE with resp_ready high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] exp_sum, input logic exp_ovf);
        logic [31:0] bx;
        logic [16:0] lo;
        bx = sub ? ~b : b;
        lo = {1'b0, a[15:0]} + {1'b0, bx[15:0]} + {16'd0, sub};
        req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        #1;
        check({tag, "_ready"}, {31'd0, req0_ready}, 32'd1);
        check({tag, "_idle_add_a"}, {16'd0, add_a}, 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check({tag, "_lo_a"}, {16'd0, add_a}, {16'd0, a[15:0]});
        check({tag, "_lo_b"}, {16'd0, add_b}, {16'd0, bx[15:0]});
        check({tag, "_lo_cin"}, {31'd0, add_cin}, {31'd0, sub});
        tick();
        check({tag, "_hi_a"}, {16'd0, add_a}, {16'd0, a[31:16]});
        check({tag, "_hi_cin"}, {31'd0, add_cin}, {31'd0, lo[16]});
        check({tag, "_hi_valid"}, {31'd0, resp_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_sum"}, resp_sum, exp_sum);
        check({tag, "_ovf"}, {31'd0, resp_ovf}, {31'd0, exp_ovf});
        check({tag, "_id"}, {31'd0, resp_id}, 32'd0);
        check({tag, "_done_add_b"}, {16'd0, add_b}, 32'd0);
        tick();
        check({tag, "_back_idle"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int          acc_cyc[$];
        logic        acc_id[$];
        int          nresp;
        logic        saw_resp;
        logic [31:0] exp_rsum [2];

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        resp_ready = 1'b1;

        // Reset state: readies stay low while rst is high even with both requests valid.
        tick();
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_sum", resp_sum, 32'd0);
        check("rst_add_a", {16'd0, add_a}, 32'd0);
        check("rst_add_cin", {31'd0, add_cin}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;

        // Arithmetic vectors.
        run_op("carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0);
        run_op("pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1);
        run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1);
        run_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0);
        run_op("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0);

        // Arbitration from reset: both valid continuously, grants 0,1,0,1 every 4 cycles.
        rst = 1'b1;
        req0_a = 32'd1;  req0_b = 32'd2; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'd10; req1_b = 32'd3; req1_sub = 1'b1; req1_valid = 1'b1;
        do_reset();
        exp_rsum[0] = 32'd3;
        exp_rsum[1] = 32'd7;
        nresp = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (req0_ready && req1_ready) check("arb_both_ready", 32'd1, 32'd0);
            if (req0_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b0); end
            if (req1_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b1); end
            if (resp_valid) begin
                check("arb_resp_id", {31'd0, resp_id}, nresp % 2);
                check("arb_resp_sum", resp_sum, exp_rsum[nresp % 2]);
                nresp++;
            end
            tick();
        end
        check("arb_accepts", acc_cyc.size(), 32'd4);
        check("arb_resps", nresp, 32'd4);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) begin
            check("arb_order", {31'd0, acc_id[i]}, i % 2);
            check("arb_spacing", acc_cyc[i], 4 * i);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Single requester 1 back-to-back, then req0 arrives while req1 is served.
        acc_cyc.delete();
        acc_id.delete();
        do_reset();
        req1_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            if (cyc == 9) begin
                req0_valid = 1'b1;
                #1;
            end
            if (req0_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b0); end
            if (req1_ready) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b1); end
            if (resp_valid) check("single_resp_id", {31'd0, resp_id}, 32'd1);
            tick();
        end
        check("single_accepts", acc_cyc.size(), 32'd4);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) begin
            check("single_spacing", acc_cyc[i], 4 * i);
            check("single_order", {31'd0, acc_id[i]}, (i < 3) ? 32'd1 : 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: resp_ready low for 5 cycles keeps the response stable for 6.
        do_reset();
        resp_ready = 1'b0;
        req0_a = 32'h12345678; req0_b = 32'h11111111; req0_sub = 1'b0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        tick();
        tick();
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 5) begin
                resp_ready = 1'b1;
                #1;
            end
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_sum", resp_sum, 32'h23456789);
            check("bp_ovf", {31'd0, resp_ovf}, 32'd0);
            check("bp_id", {31'd0, resp_id}, 32'd0);
            check("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        check("bp_released", {31'd0, resp_valid}, 32'd0);
        check("bp_next_grant1", {31'd0, req1_ready}, 32'd1);
        req1_valid = 1'b0;
        #1;

        // Reset during HI aborts the operation.
        do_reset();
        req1_a = 32'h00000100; req1_b = 32'h00000200; req1_sub = 1'b0; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_sum", resp_sum, 32'd0);
        check("mid_rst_ovf", {31'd0, resp_ovf}, 32'd0);
        check("mid_rst_id", {31'd0, resp_id}, 32'd0);
        check("mid_rst_add", {15'd0, add_cin, add_a}, 32'd0);
        check("mid_rst_add_b", {16'd0, add_b}, 32'd0);
        check("mid_rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
        rst = 1'b0;
        #1;
        saw_resp = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (resp_valid) saw_resp = 1'b1;
            tick();
        end
        check("mid_rst_no_resp", {31'd0, saw_resp}, 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("post_rst_grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
